hex_entry_buffer: RTL and testbench

Upstream feeder for the seven-segment driver. It consumes ASCII key events from the keyboard decoder and builds an 8-digit hex entry, shifting new digits in from the right. It drives the driver's 32-bit "display" and 8-bit "digit_enable" inputs, blanks leading digits, and supports backspace, clear and commit. On overflow it flashes the display.

---
 rtl/hex_entry_buffer.sv | 137 +++++++++++++
 tb/tb_hex_entry_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_entry_buffer.sv
// Hex entry buffer feeding the seven-segment driver: collects ASCII hex keys into
// an 8-digit right-shifting entry with backspace, clear, commit and overflow flash.
module hex_entry_buffer #(
   parameter int CLOCK_FREQ = 100000000,
   parameter int BLINK_MS   = 250
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        key_valid,
   input  logic [7:0]  key_code,
   output logic        key_ready,
   output logic [31:0] display,
   output logic [7:0]  digit_enable,
   output logic [3:0]  digit_count,
   output logic [31:0] value,
   output logic        value_valid
);

   localparam int          BLINK_CYC    = (CLOCK_FREQ / 1000) * BLINK_MS;
   localparam logic [31:0] BLINK_RELOAD = 32'(BLINK_CYC - 1);

   typedef enum logic [1:0] {IDLE, DECODE, FLASH} state_t;

   state_t      state_q;
   logic [7:0]  key_q;
   logic [31:0] display_q;
   logic [31:0] value_q;
   logic [31:0] blink_q;
   logic [3:0]  count_q;
   logic [1:0]  phase_q;
   logic        blank_q;
   logic        value_valid_q;

   logic        is_hex_d;
   logic [3:0]  nibble_d;

   // Letters share the low nibble pattern for both cases: 'A'/'a' -> 1, so add 9.
   always_comb begin
      is_hex_d = 1'b1;
      nibble_d = 4'h0;
      if (key_q >= 8'h30 && key_q <= 8'h39)
         nibble_d = key_q[3:0];
      else if ((key_q >= 8'h41 && key_q <= 8'h46) || (key_q >= 8'h61 && key_q <= 8'h66))
         nibble_d = key_q[3:0] + 4'd9;
      else
         is_hex_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= IDLE;
         key_q         <= 8'h00;
         display_q     <= 32'h0;
         value_q       <= 32'h0;
         blink_q       <= 32'h0;
         count_q       <= 4'd0;
         phase_q       <= 2'd0;
         blank_q       <= 1'b0;
         value_valid_q <= 1'b0;
      end else begin
         value_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (key_valid) begin
                  key_q   <= key_code;
                  state_q <= DECODE;
               end
            end
            DECODE: begin
               state_q <= IDLE;
               if (is_hex_d) begin
                  if (count_q < 4'd8) begin
                     display_q <= {display_q[27:0], nibble_d};
                     count_q   <= count_q + 4'd1;
                  end else begin
                     state_q <= FLASH;
                     blink_q <= BLINK_RELOAD;
                     phase_q <= 2'd0;
                     blank_q <= 1'b1;
                  end
               end else begin
                  case (key_q)
                     8'h08: begin
                        if (count_q != 4'd0) begin
                           display_q <= {4'h0, display_q[31:4]};
                           count_q   <= count_q - 4'd1;
                        end
                     end
                     8'h1B: begin
                        display_q <= 32'h0;
                        count_q   <= 4'd0;
                     end
                     8'h0D: begin
                        value_q       <= display_q;
                        value_valid_q <= 1'b1;
                        display_q     <= 32'h0;
                        count_q       <= 4'd0;
                     end
                     default: ;
                  endcase
               end
            end
            FLASH: begin
               if (blink_q == 32'h0) begin
                  blink_q <= BLINK_RELOAD;
                  phase_q <= phase_q + 2'd1;
                  if (phase_q == 2'd3) begin
                     blank_q <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     blank_q <= ~blank_q;
                  end
               end else begin
                  blink_q <= blink_q - 32'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Digit 0 stays lit with an empty entry so a single "0" is visible.
   for (genvar gi = 0; gi < 8; gi++) begin : g_enable
      if (gi == 0) begin : g_first
         assign digit_enable[gi] = ~blank_q;
      end else begin : g_rest
         assign digit_enable[gi] = ~blank_q & (count_q > 4'(gi));
      end
   end

   assign key_ready   = (state_q == IDLE);
   assign display     = display_q;
   assign digit_count = count_q;
   assign value       = value_q;
   assign value_valid = value_valid_q;

endmodule

// File: tb/tb_hex_entry_buffer.sv
// Self-checking bench: directed vector table, hand-written reset/flash sequences,
// and randomized keys compared against a digit-queue reference model.
module tb_hex_entry_buffer;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        key_valid = 1'b0;
   logic [7:0]  key_code = 8'h00;
   logic        key_ready;
   logic [31:0] display;
   logic [7:0]  digit_enable;
   logic [3:0]  digit_count;
   logic [31:0] value;
   logic        value_valid;

   hex_entry_buffer #(.CLOCK_FREQ(4000), .BLINK_MS(1)) dut (
      .clk(clk), .resetn(resetn), .key_valid(key_valid), .key_code(key_code),
      .key_ready(key_ready), .display(display), .digit_enable(digit_enable),
      .digit_count(digit_count), .value(value), .value_valid(value_valid)
   );

   always #5 clk = ~clk;

   int total = 0;
   int passed = 0;

   int          q[$];
   logic [31:0] m_value;

   typedef struct {
      logic [7:0]  code;
      logic [31:0] disp;
      logic [3:0]  cnt;
      logic [7:0]  en;
      logic        vv;
      logic [31:0] val;
   } vec_t;
   vec_t tbl[25];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic int hexval(input logic [7:0] c);
      if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
      if (c >= 8'h41 && c <= 8'h46) return int'(c) - 65 + 10;
      if (c >= 8'h61 && c <= 8'h66) return int'(c) - 97 + 10;
      return -1;
   endfunction

   function automatic logic [31:0] m_display();
      logic [31:0] d = 32'h0;
      foreach (q[i]) d = (d << 4) | 32'(q[i]);
      return d;
   endfunction

   function automatic logic [7:0] m_enable();
      if (q.size() == 0) return 8'h01;
      return 8'((1 << q.size()) - 1);
   endfunction

   // Apply a key to the model; returns whether a commit strobe and a flash are expected.
   task automatic model_apply(input logic [7:0] code, output bit vv, output bit fl);
      int n = hexval(code);
      vv = 0;
      fl = 0;
      if (n >= 0) begin
         if (q.size() < 8) q.push_back(n);
         else fl = 1;
      end else if (code == 8'h08) begin
         if (q.size() > 0) void'(q.pop_back());
      end else if (code == 8'h1B) begin
         q.delete();
      end else if (code == 8'h0D) begin
         m_value = m_display();
         vv = 1;
         q.delete();
      end
   endtask

   // Handshake one key; returns at the negedge after the DECODE edge.
   task automatic press(input logic [7:0] code);
      int w = 0;
      while (!key_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!key_ready) chk("ready_timeout", {31'h0, key_ready}, 32'h1);
      key_valid = 1'b1;
      key_code  = code;
      @(negedge clk);
      key_valid = 1'b0;
      chk("ready_in_decode", {31'h0, key_ready}, 32'h0);
      @(negedge clk);
   endtask

   task automatic model_key(input logic [7:0] code);
      bit vv, fl;
      model_apply(code, vv, fl);
      press(code);
      if (fl) begin
         for (int i = 0; i < 16; i++) begin
            chk($sformatf("flash_en[%0d]", i), {24'h0, digit_enable}, ((i / 4) % 2) ? 32'hFF : 32'h00);
            chk("flash_ready", {31'h0, key_ready}, 32'h0);
            chk("flash_display", display, m_display());
            @(negedge clk);
         end
         chk("flash_done_ready", {31'h0, key_ready}, 32'h1);
         chk("flash_done_en", {24'h0, digit_enable}, 32'hFF);
      end else begin
         chk("m_display", display, m_display());
         chk("m_count", {28'h0, digit_count}, 32'(q.size()));
         chk("m_enable", {24'h0, digit_enable}, {24'h0, m_enable()});
         chk("m_vv", {31'h0, value_valid}, {31'h0, vv});
         chk("m_value", value, m_value);
         @(negedge clk);
         chk("m_vv_drop", {31'h0, value_valid}, 32'h0);
      end
      $display("key %h -> display %h count %0d en %h value %h", code, display, digit_count,
               digit_enable, value);
   endtask

   function automatic vec_t mk(input logic [7:0] c, input logic [31:0] d, input logic [3:0] n,
                               input logic [7:0] e, input logic v, input logic [31:0] val);
      vec_t r;
      r.code = c; r.disp = d; r.cnt = n; r.en = e; r.vv = v; r.val = val;
      return r;
   endfunction

   initial begin
      logic [31:0] d;
      logic [7:0]  code;

      tbl[0] = mk(8'h31, 32'h1,    4'd1, 8'h01, 1'b0, 32'h0);
      tbl[1] = mk(8'h61, 32'h1A,   4'd2, 8'h03, 1'b0, 32'h0);
      tbl[2] = mk(8'h46, 32'h1AF,  4'd3, 8'h07, 1'b0, 32'h0);
      tbl[3] = mk(8'h08, 32'h1A,   4'd2, 8'h03, 1'b0, 32'h0);
      tbl[4] = mk(8'h08, 32'h1,    4'd1, 8'h01, 1'b0, 32'h0);
      tbl[5] = mk(8'h08, 32'h0,    4'd0, 8'h01, 1'b0, 32'h0);
      tbl[6] = mk(8'h08, 32'h0,    4'd0, 8'h01, 1'b0, 32'h0);
      d = 32'h0;
      for (int k = 1; k <= 8; k++) begin
         d = (d << 4) | 32'(k);
         tbl[6 + k] = mk(8'(48 + k), d, 4'(k), 8'((1 << k) - 1), 1'b0, 32'h0);
      end
      tbl[15] = mk(8'h0D, 32'h0, 4'd0, 8'h01, 1'b1, 32'h1234_5678);
      tbl[16] = mk(8'h39, 32'h9, 4'd1, 8'h01, 1'b0, 32'h1234_5678);
      tbl[17] = mk(8'h1B, 32'h0, 4'd0, 8'h01, 1'b0, 32'h1234_5678);
      tbl[18] = mk(8'h20, 32'h0, 4'd0, 8'h01, 1'b0, 32'h1234_5678);
      tbl[19] = mk(8'h63, 32'hC, 4'd1, 8'h01, 1'b0, 32'h1234_5678);
      tbl[20] = mk(8'h20, 32'hC, 4'd1, 8'h01, 1'b0, 32'h1234_5678);
      tbl[21] = mk(8'h0D, 32'h0, 4'd0, 8'h01, 1'b1, 32'hC);
      tbl[22] = mk(8'h0D, 32'h0, 4'd0, 8'h01, 1'b1, 32'h0);
      tbl[23] = mk(8'h37, 32'h7, 4'd1, 8'h01, 1'b0, 32'h0);
      tbl[24] = mk(8'h0D, 32'h0, 4'd0, 8'h01, 1'b1, 32'h7);

      // Reset state
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      chk("rst_display", display, 32'h0);
      chk("rst_en", {24'h0, digit_enable}, 32'h01);
      chk("rst_count", {28'h0, digit_count}, 32'h0);
      chk("rst_ready", {31'h0, key_ready}, 32'h1);
      chk("rst_vv", {31'h0, value_valid}, 32'h0);
      chk("rst_value", value, 32'h0);

      // Directed vector table
      for (int i = 0; i < 25; i++) begin
         press(tbl[i].code);
         chk($sformatf("tbl%0d_display", i), display, tbl[i].disp);
         chk($sformatf("tbl%0d_count", i), {28'h0, digit_count}, {28'h0, tbl[i].cnt});
         chk($sformatf("tbl%0d_en", i), {24'h0, digit_enable}, {24'h0, tbl[i].en});
         chk($sformatf("tbl%0d_vv", i), {31'h0, value_valid}, {31'h0, tbl[i].vv});
         chk($sformatf("tbl%0d_value", i), value, tbl[i].val);
         $display("vec %0d key %h -> display %h count %0d en %h vv %b value %h", i,
                  tbl[i].code, display, digit_count, digit_enable, value_valid, value);
         @(negedge clk);
         chk($sformatf("tbl%0d_vv_drop", i), {31'h0, value_valid}, 32'h0);
      end

      // Overflow: eight digits, then a ninth triggers the flash
      q.delete();
      m_value = 32'h7;
      for (int k = 0; k < 8; k++) model_key(8'h41 + 8'(k % 6));
      model_key(8'h35);

      // Reset in the middle of a flash
      press(8'h62);
      repeat (5) @(negedge clk);
      chk("midflash_ready", {31'h0, key_ready}, 32'h0);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      chk("rst2_display", display, 32'h0);
      chk("rst2_count", {28'h0, digit_count}, 32'h0);
      chk("rst2_en", {24'h0, digit_enable}, 32'h01);
      chk("rst2_ready", {31'h0, key_ready}, 32'h1);
      chk("rst2_value", value, 32'h0);
      $display("reset mid-flash -> display %h count %0d en %h", display, digit_count, digit_enable);

      // Key held through DECODE, reset there, then accepted once ready returns
      key_valid = 1'b1;
      key_code  = 8'h35;
      @(negedge clk);
      chk("held_decode_ready", {31'h0, key_ready}, 32'h0);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      chk("held_rst_display", display, 32'h0);
      chk("held_rst_count", {28'h0, digit_count}, 32'h0);
      chk("held_rst_ready", {31'h0, key_ready}, 32'h1);
      @(negedge clk);
      chk("held_decode2_ready", {31'h0, key_ready}, 32'h0);
      key_valid = 1'b0;
      @(negedge clk);
      chk("held_display", display, 32'h5);
      chk("held_count", {28'h0, digit_count}, 32'h1);
      $display("held key -> display %h count %0d", display, digit_count);

      // Randomized keys against the reference model
      q.delete();
      q.push_back(5);
      m_value = 32'h0;
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 11))
            0, 1, 2:  code = 8'h30 + 8'($urandom_range(0, 9));
            3:        code = 8'h41 + 8'($urandom_range(0, 5));
            4:        code = 8'h61 + 8'($urandom_range(0, 5));
            5, 6:     code = 8'h08;
            7:        code = 8'h1B;
            8:        code = 8'h0D;
            9:        code = 8'($urandom);
            default:  code = 8'h30 + 8'($urandom_range(0, 9));
         endcase
         model_key(code);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
